add_cmp_arbiter: RTL and testbench

ADD_CMP_ARBITER -- requirements
Module: add_cmp_arbiter

---
 rtl/add_cmp_arbiter.sv | 152 +++++++++++++++
 tb/tb_add_cmp_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/add_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : add_cmp_arbiter
// Description : Two-requester round-robin arbiter feeding a shared 3-bit
//               add / unsigned-compare unit. One operation is in flight at
//               a time (IDLE -> EXEC -> RESP), and the result is held under
//               res_valid/res_ready back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module add_cmp_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_op,
    input  logic [2:0] req0_a,
    input  logic [2:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_op,
    input  logic [2:0] req1_a,
    input  logic [2:0] req1_b,
    output logic       req1_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_id,
    output logic [2:0] res_sum,
    output logic       res_cout,
    output logic       res_lt,
    output logic       res_eq,
    output logic       res_gt,
    output logic [7:0] ops_done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0] r_state;
    logic       r_ptr;
    logic       r_op;
    logic [2:0] r_a;
    logic [2:0] r_b;
    logic       r_id;
    logic       r_res_valid;
    logic       r_res_id;
    logic [2:0] r_res_sum;
    logic       r_res_cout;
    logic       r_res_lt;
    logic       r_res_eq;
    logic       r_res_gt;
    logic [7:0] r_ops_done;

    logic       w_idle;
    logic       w_grant0;
    logic       w_grant1;
    logic [3:0] w_sum_full;

    // Grant is combinational so a requester sees ready in the same cycle it
    // raises valid; the pointer only breaks ties when both are valid.
    always_comb begin
        w_idle     = (r_state == c_ST_IDLE) && !rst;
        w_grant0   = w_idle && req0_valid && (!req1_valid || (r_ptr == 1'b0));
        w_grant1   = w_idle && req1_valid && (!req0_valid || (r_ptr == 1'b1));
        w_sum_full = {1'b0, r_a} + {1'b0, r_b};
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Control FSM with registered result outputs and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= RR_INIT;
            r_op        <= 1'b0;
            r_a         <= 3'd0;
            r_b         <= 3'd0;
            r_id        <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_sum   <= 3'd0;
            r_res_cout  <= 1'b0;
            r_res_lt    <= 1'b0;
            r_res_eq    <= 1'b0;
            r_res_gt    <= 1'b0;
            r_ops_done  <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant0) begin
                        r_op    <= req0_op;
                        r_a     <= req0_a;
                        r_b     <= req0_b;
                        r_id    <= 1'b0;
                        r_ptr   <= 1'b1;
                        r_state <= c_ST_EXEC;
                    end else if (w_grant1) begin
                        r_op    <= req1_op;
                        r_a     <= req1_a;
                        r_b     <= req1_b;
                        r_id    <= 1'b1;
                        r_ptr   <= 1'b0;
                        r_state <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_res_id <= r_id;
                    if (r_op == 1'b0) begin
                        r_res_sum  <= w_sum_full[2:0];
                        r_res_cout <= w_sum_full[3];
                        r_res_lt   <= 1'b0;
                        r_res_eq   <= 1'b0;
                        r_res_gt   <= 1'b0;
                    end else begin
                        r_res_sum  <= 3'd0;
                        r_res_cout <= 1'b0;
                        r_res_lt   <= (r_a <  r_b);
                        r_res_eq   <= (r_a == r_b);
                        r_res_gt   <= (r_a >  r_b);
                    end
                    r_res_valid <= 1'b1;
                    r_state     <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    // Result fields stay put after the handshake; only valid drops.
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 8'd1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_lt    = r_res_lt;
    assign res_eq    = r_res_eq;
    assign res_gt    = r_res_gt;
    assign ops_done  = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_add_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_cmp_arbiter
// Description : Directed self-checking bench for add_cmp_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_cmp_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_op, req0_ready;
    logic [2:0] req0_a, req0_b;
    logic       req1_valid, req1_op, req1_ready;
    logic [2:0] req1_a, req1_b;
    logic       res_valid, res_ready, res_id, res_cout, res_lt, res_eq, res_gt;
    logic [2:0] res_sum;
    logic [7:0] ops_done;

    int checks = 0;
    int errors = 0;

    add_cmp_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_sum(res_sum),
        .res_cout(res_cout), .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result bundle packed as {valid,id,sum[2:0],cout,lt,eq,gt}
    function automatic logic [31:0] res_pack();
        return {23'd0, res_valid, res_id, res_sum, res_cout, res_lt, res_eq, res_gt};
    endfunction

    function automatic logic [31:0] exp_pack(input logic v, input logic id, input logic [2:0] s,
                                             input logic c, input logic lt, input logic eq, input logic gt);
        return {23'd0, v, id, s, c, lt, eq, gt};
    endfunction

    initial begin
        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 3'd5; req0_b = 3'd6;
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 3'd0; req1_b = 3'd0;

        // Reset: readies held low, outputs cleared
        tick(); tick();
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        check("rst_res", res_pack(), exp_pack(0,0,0,0,0,0,0));
        check("rst_ops", {24'd0, ops_done}, 32'd0);

        // Add with carry from requester 0: 5+6 = 11 -> sum 3, cout 1
        rst = 1'b0; req1_valid = 1'b0;
        #1;
        check("add_ready0", {31'd0, req0_ready}, 32'd1);
        check("add_ready1", {31'd0, req1_ready}, 32'd0);
        tick(); req0_valid = 1'b0;
        check("exec_res_valid", {31'd0, res_valid}, 32'd0);
        check("exec_ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        check("add_res", res_pack(), exp_pack(1,0,3'd3,1,0,0,0));
        tick();
        check("add_done_valid", {31'd0, res_valid}, 32'd0);
        check("add_ops", {24'd0, ops_done}, 32'd1);

        // Compare from requester 1: 3 < 5
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 3'd3; req1_b = 3'd5;
        #1;
        check("cmp_ready1", {31'd0, req1_ready}, 32'd1);
        tick(); req1_valid = 1'b0; tick();
        check("cmp_lt", res_pack(), exp_pack(1,1,3'd0,0,1,0,0));
        tick();

        // Compare 7 == 7
        req1_valid = 1'b1; req1_a = 3'd7; req1_b = 3'd7;
        tick(); req1_valid = 1'b0; tick();
        check("cmp_eq", res_pack(), exp_pack(1,1,3'd0,0,0,1,0));
        tick();

        // Compare 6 > 2 from requester 0
        req0_valid = 1'b1; req0_op = 1'b1; req0_a = 3'd6; req0_b = 3'd2;
        tick(); req0_valid = 1'b0; tick();
        check("cmp_gt", res_pack(), exp_pack(1,0,3'd0,0,0,0,1));
        tick();
        check("cmp_ops", {24'd0, ops_done}, 32'd4);

        // Contention after reset: alternating grants 0,1,0,1
        rst = 1'b1; tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 3'd1; req0_b = 3'd2;
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 3'd7; req1_b = 3'd7;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_ready1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick(); tick();
            if (i % 2 == 0) check("cont_res", res_pack(), exp_pack(1,0,3'd3,0,0,0,0));
            else            check("cont_res", res_pack(), exp_pack(1,1,3'd6,1,0,0,0));
            tick();
        end
        req1_valid = 1'b0;
        check("cont_ops", {24'd0, ops_done}, 32'd4);

        // Back-pressure: 4+4 = 8 -> sum 0, cout 1, held while res_ready low
        req0_a = 3'd4; req0_b = 3'd4; res_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_res", res_pack(), exp_pack(1,0,3'd0,1,0,0,0));
            check("bp_ready0", {31'd0, req0_ready}, 32'd0);
            check("bp_ops", {24'd0, ops_done}, 32'd4);
            tick();
        end
        res_ready = 1'b1;
        tick(); req0_valid = 1'b0;
        check("bp_done_valid", {31'd0, res_valid}, 32'd0);
        check("bp_ops_inc", {24'd0, ops_done}, 32'd5);
        tick();
        check("bp_ops_once", {24'd0, ops_done}, 32'd5);

        // Reset mid-RESP after a requester-0 accept (pointer moved to 1)
        req0_valid = 1'b1; req0_a = 3'd2; req0_b = 3'd3;
        tick(); req0_valid = 1'b0; res_ready = 1'b0; tick();
        check("mid_resp_valid", {31'd0, res_valid}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_res", res_pack(), exp_pack(0,0,0,0,0,0,0));
        check("mid_rst_ops", {24'd0, ops_done}, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        #1;
        check("mid_rst_ptr0", {31'd0, req0_ready}, 32'd1);
        check("mid_rst_ptr1", {31'd0, req1_ready}, 32'd0);
        req1_valid = 1'b0;

        // Counter wrap: 256 completions
        req0_op = 1'b0; req0_a = 3'd1; req0_b = 3'd1;
        for (int i = 0; i < 256; i++) begin
            tick(); tick(); tick();
            if (i == 254) check("wrap_255", {24'd0, ops_done}, 32'd255);
        end
        req0_valid = 1'b0;
        check("wrap_0", {24'd0, ops_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
